// File: rtl/mmu_ext_burst_master_pkg.sv
// mmu_ext_burst_master_pkg: shared widths, FSM states and burst-size check for the ext burst master
// no ports; imported by the interface, the line buffer and the top
package mmu_ext_burst_master_pkg;
   localparam int PADDR_W   = 33;
   localparam int BEAT_W    = 128;
   localparam int MASK_W    = BEAT_W / 8;
   localparam int MAX_BEATS = 4;
   localparam int LINE_W    = BEAT_W * MAX_BEATS;
   localparam int LMASK_W   = MASK_W * MAX_BEATS;
   localparam int TIMEOUT   = 256;
   localparam int TMO_W     = $clog2(TIMEOUT) + 1;
   localparam int CTR_W     = $clog2(MAX_BEATS);
   typedef enum logic [2:0] {IDLE, WR_BEAT, WR_WAIT, RD_CMD, RD_DATA, RSP} state_t;
   function automatic logic beats_ok(input logic [2:0] b);
      return b != 3'd0 && b <= 3'(MAX_BEATS);
   endfunction
endpackage

// File: rtl/mmu_ext_burst_master_if.sv
// mmu_ext_burst_master_if: external memory burst bus between the MMU initiator and the memory controller
// master: drives rden/wren/mask/burst_size/paddr/wdat/burst_start/burst_end/burst_vld, samples rd_ack/wr_ack/rdat/rdy
// slave: the mirror image
interface mmu_ext_burst_master_if;
   import mmu_ext_burst_master_pkg::*;
   logic               rden;
   logic               wren;
   logic [MASK_W-1:0]  mask;
   logic [2:0]         burst_size;
   logic [PADDR_W-1:0] paddr;
   logic [BEAT_W-1:0]  wdat;
   logic               burst_start;
   logic               burst_end;
   logic               burst_vld;
   logic               rd_ack;
   logic               wr_ack;
   logic [BEAT_W-1:0]  rdat;
   logic               rdy;
   modport master (
      output rden, wren, mask, burst_size, paddr, wdat, burst_start, burst_end, burst_vld,
      input  rd_ack, wr_ack, rdat, rdy
   );
   modport slave (
      input  rden, wren, mask, burst_size, paddr, wdat, burst_start, burst_end, burst_vld,
      output rd_ack, wr_ack, rdat, rdy
   );
endinterface

// File: rtl/mmu_ext_burst_master_line_buf.sv
// mmu_ext_burst_master_line_buf: 512-bit line plus byte-mask latch with per-beat read mux and capture
// clk/rst; ld loads ld_line/ld_mask; cap writes cap_beat into slice idx; beat/beat_mask are slice idx; line is the whole line
module mmu_ext_burst_master_line_buf
   import mmu_ext_burst_master_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               ld,
   input  logic [LINE_W-1:0]  ld_line,
   input  logic [LMASK_W-1:0] ld_mask,
   input  logic               cap,
   input  logic [CTR_W-1:0]   idx,
   input  logic [BEAT_W-1:0]  cap_beat,
   output logic [BEAT_W-1:0]  beat,
   output logic [MASK_W-1:0]  beat_mask,
   output logic [LINE_W-1:0]  line
);
   logic [LMASK_W-1:0] mask;
   always_ff @(posedge clk) begin
      if (rst) begin
         line <= '0;
         mask <= '0;
      end else if (ld) begin
         line <= ld_line;
         mask <= ld_mask;
      end else if (cap) begin
         line[idx*BEAT_W +: BEAT_W] <= cap_beat;
      end
   end
   assign beat      = line[idx*BEAT_W +: BEAT_W];
   assign beat_mask = mask[idx*MASK_W +: MASK_W];
endmodule

// File: rtl/mmu_ext_burst_master.sv
// mmu_ext_burst_master: slices a 512-bit line request into 128-bit ext-memory beats and reports a response
// clk/rst; i_req_*/o_req_rdy line request; o_rsp_*/i_rsp_rdy response; bus is the ext memory burst master port
module mmu_ext_burst_master
   import mmu_ext_burst_master_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_req_vld,
   input  logic                 i_req_wr,
   input  logic [PADDR_W-1:0]   i_req_paddr,
   input  logic [LINE_W-1:0]    i_req_wdat,
   input  logic [LMASK_W-1:0]   i_req_mask,
   input  logic [2:0]           i_req_beats,
   output logic                 o_req_rdy,
   output logic                 o_rsp_vld,
   input  logic                 i_rsp_rdy,
   output logic                 o_rsp_wr,
   output logic                 o_rsp_err,
   output logic [LINE_W-1:0]    o_rsp_rdat,
   mmu_ext_burst_master_if.master bus
);
   state_t             state, state_n;
   logic [CTR_W-1:0]   beat_ctr;
   logic [TMO_W-1:0]   tmo_ctr;
   logic [2:0]         beats_q;
   logic [PADDR_W-1:0] paddr_q;
   logic               wr_q, err_q, err_n;
   logic               accept, last, tmo, wb, ww, rc, rd, rsp;
   logic [BEAT_W-1:0]  cur_wdat;
   logic [MASK_W-1:0]  cur_mask;
   logic [LINE_W-1:0]  line;
   assign wb     = state == WR_BEAT;
   assign ww     = state == WR_WAIT;
   assign rc     = state == RD_CMD;
   assign rd     = state == RD_DATA;
   assign rsp    = state == RSP;
   assign accept = i_req_vld & o_req_rdy;
   assign last   = beat_ctr == CTR_W'(beats_q - 3'd1);
   assign tmo    = tmo_ctr == TMO_W'(TIMEOUT - 1);
   always_comb begin
      state_n = state;
      err_n   = err_q;
      case (state)
         IDLE:    if (accept) begin
            state_n = !beats_ok(i_req_beats) ? RSP : i_req_wr ? WR_BEAT : RD_CMD;
            err_n   = !beats_ok(i_req_beats);
         end
         WR_BEAT: state_n = last ? WR_WAIT : WR_BEAT;
         WR_WAIT: if (bus.wr_ack | tmo) begin
            state_n = RSP;
            err_n   = ~bus.wr_ack;
         end
         RD_CMD:  state_n = RD_DATA;
         RD_DATA: if (bus.rd_ack | tmo) begin
            state_n = RSP;
            err_n   = ~(bus.rd_ack & last);
         end
         RSP:     state_n = i_rsp_rdy ? IDLE : RSP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         beats_q  <= '0;
         paddr_q  <= '0;
         beat_ctr <= '0;
         tmo_ctr  <= '0;
      end else begin
         state    <= state_n;
         err_q    <= err_n;
         wr_q     <= accept ? i_req_wr : wr_q;
         beats_q  <= accept ? i_req_beats : beats_q;
         paddr_q  <= accept ? i_req_paddr : paddr_q;
         // saturates at N-1 so late read beats keep landing in the last slice
         beat_ctr <= accept ? '0 : (wb | rd) & ~last ? beat_ctr + 1'b1 : beat_ctr;
         tmo_ctr  <= accept ? '0 : (ww | rd) ? tmo_ctr + 1'b1 : tmo_ctr;
      end
   end
   mmu_ext_burst_master_line_buf u_line_buf (
      .clk       (clk),
      .rst       (rst),
      .ld        (accept),
      .ld_line   (i_req_wr ? i_req_wdat : '0),
      .ld_mask   (i_req_wr ? i_req_mask : '0),
      .cap       (rd),
      .idx       (beat_ctr),
      .cap_beat  (bus.rdat),
      .beat      (cur_wdat),
      .beat_mask (cur_mask),
      .line      (line)
   );
   assign o_req_rdy       = (state == IDLE) & bus.rdy & ~rst;
   assign o_rsp_vld       = rsp;
   assign o_rsp_wr        = rsp & wr_q;
   assign o_rsp_err       = rsp & err_q;
   assign o_rsp_rdat      = rsp & ~wr_q ? line : '0;
   assign bus.rden        = rc;
   assign bus.wren        = wb & (beat_ctr == '0);
   assign bus.mask        = wb ? cur_mask : '0;
   assign bus.wdat        = wb ? cur_wdat : '0;
   assign bus.burst_size  = (wb | ww | rc | rd) ? beats_q : '0;
   assign bus.paddr       = (wb | ww | rc | rd) ? paddr_q : '0;
   assign bus.burst_start = rc | (wb & (beat_ctr == '0));
   assign bus.burst_end   = (wb | rc | rd) & last;
   assign bus.burst_vld   = wb | rc | rd;
endmodule
